// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the ID/EX pipeline controller: FSM state encoding,
// counter sizing and the helper that turns a cycle budget into a counter preload.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        FLUSH   = 2'd2
    } ctrl_state_t;

    localparam int          CountWidth = 8;
    localparam logic [31:0] StallMax   = 32'hFFFF_FFFF;

    // The cycle that triggers a multi-cycle window is itself the first cycle,
    // so the counter only has to cover the remaining cycles.
    function automatic logic [CountWidth-1:0] reload_count(input int cycles);
        return CountWidth'(cycles - 1);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load
// in EX is about to write, which the bypass network cannot satisfy in time.
module hazard_detect (
    input  logic       id_valid,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] id_rs1n,
    input  logic [4:0] id_rs2n,
    input  logic       ex_load,
    input  logic [4:0] ex_rdn,
    output logic       hazard
);

    logic rs1_match;
    logic rs2_match;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    always_comb begin
        rs1_match = id_use_rs1 && (id_rs1n == ex_rdn);
        rs2_match = id_use_rs2 && (id_rs2n == ex_rdn);
        hazard    = id_valid && ex_load && (ex_rdn != 5'd0) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/idex_ctrl.sv
// ID/EX pipeline controller: resolves flushes, taken branches, load-use stalls
// and multicycle EX operations into hold/flush/bubble strobes plus a stall counter.
module idex_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int McLatency   = 8,
    parameter int FlushCycles = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        id_mc,
    input  logic [4:0]  id_rs1n,
    input  logic [4:0]  id_rs2n,
    input  logic [4:0]  ex_rdn,
    input  logic        ex_load,
    input  logic        ex_branch_taken,
    input  logic        flush_req,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        ex_hold,
    output logic [1:0]  state,
    output logic [31:0] stall_cycles
);

    ctrl_state_t           state_q;
    ctrl_state_t           state_d;
    logic [CountWidth-1:0] count_q;
    logic [CountWidth-1:0] count_d;
    logic [31:0]           stall_q;
    logic                  load_use;

    logic raw_pc_hold;
    logic raw_ifid_hold;
    logic raw_ifid_flush;
    logic raw_idex_bubble;
    logic raw_ex_hold;

    hazard_detect u_hazard_detect (
        .id_valid   (id_valid),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rs1n    (id_rs1n),
        .id_rs2n    (id_rs2n),
        .ex_load    (ex_load),
        .ex_rdn     (ex_rdn),
        .hazard     (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        raw_pc_hold     = 1'b0;
        raw_ifid_hold   = 1'b0;
        raw_ifid_flush  = 1'b0;
        raw_idex_bubble = 1'b0;
        raw_ex_hold     = 1'b0;

        case (state_q)
            RUN: begin
                if (flush_req) begin
                    raw_ifid_flush  = 1'b1;
                    raw_idex_bubble = 1'b1;
                    if (FlushCycles > 1) begin
                        state_d = FLUSH;
                        count_d = reload_count(FlushCycles);
                    end
                end else if (ex_branch_taken) begin
                    raw_ifid_flush  = 1'b1;
                    raw_idex_bubble = 1'b1;
                end else if (load_use) begin
                    raw_pc_hold     = 1'b1;
                    raw_ifid_hold   = 1'b1;
                    raw_idex_bubble = 1'b1;
                end else if (id_valid && id_mc) begin
                    if (McLatency > 1) begin
                        state_d = MC_WAIT;
                        count_d = reload_count(McLatency);
                    end
                end
            end

            // Branch and load-use events are deliberately ignored here: EX is
            // still occupied by the multicycle op, so neither can be acted on.
            MC_WAIT: begin
                if (flush_req) begin
                    raw_ifid_flush  = 1'b1;
                    raw_idex_bubble = 1'b1;
                    if (FlushCycles > 1) begin
                        state_d = FLUSH;
                        count_d = reload_count(FlushCycles);
                    end else begin
                        state_d = RUN;
                        count_d = '0;
                    end
                end else begin
                    raw_pc_hold   = 1'b1;
                    raw_ifid_hold = 1'b1;
                    raw_ex_hold   = 1'b1;
                    if (count_q <= CountWidth'(1)) begin
                        state_d = RUN;
                        count_d = '0;
                    end else begin
                        count_d = count_q - CountWidth'(1);
                    end
                end
            end

            FLUSH: begin
                raw_ifid_flush  = 1'b1;
                raw_idex_bubble = 1'b1;
                if (flush_req) begin
                    count_d = reload_count(FlushCycles);
                end else if (count_q <= CountWidth'(1)) begin
                    state_d = RUN;
                    count_d = '0;
                end else begin
                    count_d = count_q - CountWidth'(1);
                end
            end

            default: begin
                state_d = RUN;
                count_d = '0;
            end
        endcase
    end

    // Reset must silence the strobes immediately, without waiting for a clock edge.
    always_comb begin
        pc_hold     = raw_pc_hold     && !rst;
        ifid_hold   = raw_ifid_hold   && !rst;
        ifid_flush  = raw_ifid_flush  && !rst;
        idex_bubble = raw_idex_bubble && !rst;
        ex_hold     = raw_ex_hold     && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (pc_hold && (stall_q != StallMax)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign state        = state_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_idex_ctrl.sv
// Directed self-checking bench for idex_ctrl: hazards, branches, multicycle
// waits, flushes and asynchronous reset, each against hand-computed values.
module tb_idex_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        id_mc;
    logic [4:0]  id_rs1n;
    logic [4:0]  id_rs2n;
    logic [4:0]  ex_rdn;
    logic        ex_load;
    logic        ex_branch_taken;
    logic        flush_req;
    logic        pc_hold;
    logic        ifid_hold;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        ex_hold;
    logic [1:0]  state;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Control strobes packed as {pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_hold}
    localparam logic [4:0] CtlNone   = 5'b00000;
    localparam logic [4:0] CtlStall  = 5'b11010;
    localparam logic [4:0] CtlFlush  = 5'b00110;
    localparam logic [4:0] CtlMcWait = 5'b11001;

    idex_ctrl #(
        .McLatency   (8),
        .FlushCycles (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_mc           (id_mc),
        .id_rs1n         (id_rs1n),
        .id_rs2n         (id_rs2n),
        .ex_rdn          (ex_rdn),
        .ex_load         (ex_load),
        .ex_branch_taken (ex_branch_taken),
        .flush_req       (flush_req),
        .pc_hold         (pc_hold),
        .ifid_hold       (ifid_hold),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .ex_hold         (ex_hold),
        .state           (state),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic valid, input logic use1, input logic use2,
                                 input logic mc, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic load, input logic br,
                                 input logic fl);
        id_valid        = valid;
        id_use_rs1      = use1;
        id_use_rs2      = use2;
        id_mc           = mc;
        id_rs1n         = rs1;
        id_rs2n         = rs2;
        ex_rdn          = rd;
        ex_load         = load;
        ex_branch_taken = br;
        flush_req       = fl;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] ctl();
        return {27'd0, pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_hold};
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        flush_req = 1'b1;
        id_valid  = 1'b1;
        ex_load   = 1'b1;
        #1;
        checkOutput("reset_ctl_forced_zero", ctl(), {27'd0, CtlNone});
        checkOutput("reset_state", {30'd0, state}, 32'd0);
        checkOutput("reset_stall", stall_cycles, 32'd0);
        idle();

        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("idle_ctl", ctl(), {27'd0, CtlNone});
        stepCycle();

        // Load-use through rs2
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("loaduse_rs2_ctl", ctl(), {27'd0, CtlStall});
        stepCycle();
        idle();
        #1;
        checkOutput("loaduse_rs2_after_ctl", ctl(), {27'd0, CtlNone});
        checkOutput("loaduse_rs2_state", {30'd0, state}, 32'd0);
        checkOutput("loaduse_rs2_stall", stall_cycles, 32'd1);

        // Same pattern with x0 as destination: no hazard
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("loaduse_x0_ctl", ctl(), {27'd0, CtlNone});
        stepCycle();
        checkOutput("loaduse_x0_stall", stall_cycles, 32'd1);

        // Matching register but rs1 not used: no hazard
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("rs1_unused_ctl", ctl(), {27'd0, CtlNone});
        // Now rs1 used: hazard
        id_use_rs1 = 1'b1;
        #1;
        checkOutput("loaduse_rs1_ctl", ctl(), {27'd0, CtlStall});
        stepCycle();
        idle();
        checkOutput("loaduse_rs1_stall", stall_cycles, 32'd2);

        // Taken branch
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("branch_ctl", ctl(), {27'd0, CtlFlush});
        stepCycle();
        idle();
        #1;
        checkOutput("branch_state", {30'd0, state}, 32'd0);

        // Multicycle op: 7 held cycles then RUN
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("mc_issue_ctl", ctl(), {27'd0, CtlNone});
        stepCycle();
        idle();
        for (int i = 0; i < 7; i++) begin
            #1;
            checkOutput($sformatf("mc_wait%0d_state", i), {30'd0, state}, 32'd1);
            checkOutput($sformatf("mc_wait%0d_ctl", i), ctl(), {27'd0, CtlMcWait});
            stepCycle();
        end
        #1;
        checkOutput("mc_done_state", {30'd0, state}, 32'd0);
        checkOutput("mc_done_ctl", ctl(), {27'd0, CtlNone});
        checkOutput("mc_done_stall", stall_cycles, 32'd9);

        // Flush on the third MC_WAIT cycle
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        idle();
        for (int i = 0; i < 2; i++) begin
            #1;
            checkOutput($sformatf("mcfl_wait%0d_ctl", i), ctl(), {27'd0, CtlMcWait});
            stepCycle();
        end
        flush_req = 1'b1;
        #1;
        checkOutput("mcfl_abort_ctl", ctl(), {27'd0, CtlFlush});
        stepCycle();
        idle();
        #1;
        checkOutput("mcfl_flush_state", {30'd0, state}, 32'd2);
        checkOutput("mcfl_flush_ctl", ctl(), {27'd0, CtlFlush});
        stepCycle();
        checkOutput("mcfl_done_state", {30'd0, state}, 32'd0);
        checkOutput("mcfl_done_ctl", ctl(), {27'd0, CtlNone});
        checkOutput("mcfl_stall", stall_cycles, 32'd11);

        // Flush, branch and load-use together: flush wins, no PC hold
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("prio_ctl", ctl(), {27'd0, CtlFlush});
        stepCycle();
        idle();
        #1;
        checkOutput("prio_state", {30'd0, state}, 32'd2);
        // Flush request inside FLUSH reloads the counter
        flush_req = 1'b1;
        stepCycle();
        idle();
        #1;
        checkOutput("reload_state", {30'd0, state}, 32'd2);
        checkOutput("reload_ctl", ctl(), {27'd0, CtlFlush});
        stepCycle();
        checkOutput("reload_done_state", {30'd0, state}, 32'd0);
        checkOutput("prio_stall", stall_cycles, 32'd11);

        // MC_WAIT ignores branch and load-use; then async reset mid-wait
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("mc_ignore_ctl", ctl(), {27'd0, CtlMcWait});
        stepCycle();
        idle();
        #1;
        checkOutput("mc_pre_reset_state", {30'd0, state}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_ctl", ctl(), {27'd0, CtlNone});
        checkOutput("async_rst_state", {30'd0, state}, 32'd0);
        checkOutput("async_rst_stall", stall_cycles, 32'd0);
        rst = 1'b0;
        stepCycle();
        checkOutput("post_rst_state", {30'd0, state}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd12, 5'd12, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("post_rst_loaduse_ctl", ctl(), {27'd0, CtlStall});
        stepCycle();
        idle();
        checkOutput("post_rst_stall", stall_cycles, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idex_ctrl.md
IDEX_CTRL -- requirements
Module: idex_ctrl

Interface
REQ-001 SHALL have parameter McLatency, default 8, meaning total EX cycles of a multicycle (mul/div) op, legal range 1..255.
REQ-002 SHALL have parameter FlushCycles, default 2, meaning bubble cycles inserted per external flush request, legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports id_valid, id_use_rs1, id_use_rs2, id_mc  input  1 each  ID holds valid instr / reads rs1 / reads rs2 / is multicycle op.
REQ-006 SHALL have ports id_rs1n, id_rs2n, ex_rdn  input  5 each  ID source register numbers / EX destination register number.
REQ-007 SHALL have ports ex_load, ex_branch_taken, flush_req  input  1 each  EX instr is load / EX resolved taken branch / external pipeline flush request (trap, fence).
REQ-008 SHALL have ports pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_hold  output  1 each  PC freeze / IF-ID freeze / IF-ID clear / force ID-EX register to zero / freeze ID-EX register and EX unit.
REQ-009 SHALL have ports state  output  2  current FSM state; stall_cycles  output  32  performance counter.

Function
REQ-010 SHALL implement states RUN, MC_WAIT, FLUSH; all control outputs combinational from state and inputs.
REQ-011 Load-use hazard SHALL be: id_valid & ex_load & ex_rdn!=0 & ((id_use_rs1 & id_rs1n==ex_rdn) | (id_use_rs2 & id_rs2n==ex_rdn)).
REQ-012 RUN priority SHALL be flush_req > ex_branch_taken > load-use > multicycle issue.
REQ-013 RUN + flush_req: ifid_flush=1, idex_bubble=1, pc_hold=0; next FLUSH, counter loaded FlushCycles-1; if FlushCycles==1 stay RUN.
REQ-014 RUN + ex_branch_taken: ifid_flush=1, idex_bubble=1, no holds; next RUN.
REQ-015 RUN + load-use: pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly one cycle; next RUN.
REQ-016 RUN + id_valid & id_mc, no higher-priority event: no outputs asserted this cycle; next MC_WAIT, counter loaded McLatency-1; if McLatency==1 stay RUN.
REQ-017 MC_WAIT: pc_hold=1, ifid_hold=1, ex_hold=1; counter decrements each cycle; counter==1 -> next RUN, giving exactly McLatency-1 held cycles.
REQ-018 MC_WAIT SHALL ignore ex_branch_taken and load-use (EX holds the multicycle op).
REQ-019 MC_WAIT + flush_req: abort, ex_hold=0, ifid_flush=1, idex_bubble=1; next FLUSH with counter FlushCycles-1 (or RUN if FlushCycles==1).
REQ-020 FLUSH: ifid_flush=1, idex_bubble=1, holds 0; counter decrements; counter==1 -> RUN; flush_req in FLUSH reloads counter FlushCycles-1.
REQ-021 Outputs SHALL be 0 in RUN with no event; ifid_hold and ifid_flush SHALL never both be 1.
REQ-022 stall_cycles SHALL increment by 1 each cycle pc_hold==1 and saturate at 32'hFFFF_FFFF.
REQ-023 Counter SHALL be 8 bits, never wraps below 0.

Reset
REQ-024 rst=1 SHALL immediately force state=RUN, counter=0, stall_cycles=0, all control outputs 0 regardless of clk.
REQ-025 rst asserted mid-MC_WAIT or mid-FLUSH SHALL abandon the operation; first cycle after release behaves as RUN.

Structure
REQ-026 State enum and state encodings (RUN=0, MC_WAIT=1, FLUSH=2) SHALL live in shared package pipe_ctrl_pkg.
REQ-027 Load-use comparator SHALL be sub-module hazard_detect (combinational, 1-bit hazard output).

Verification
REQ-028 ex_load=1, ex_rdn=5, id_rs2n=5, id_use_rs2=1, id_valid=1 -> pc_hold/ifid_hold/idex_bubble high one cycle, stall_cycles=1.
REQ-029 Same as REQ-028 with ex_rdn=0 -> no stall, all outputs 0.
REQ-030 id_mc=1 issued in RUN, McLatency=8 -> state MC_WAIT, ex_hold high exactly 7 cycles, then RUN; stall_cycles=7.
REQ-031 flush_req on 3rd MC_WAIT cycle, FlushCycles=2 -> ex_hold drops that cycle, idex_bubble high 2 cycles, then RUN.
REQ-032 flush_req and ex_branch_taken and load-use together in RUN -> FLUSH path taken, pc_hold=0.
REQ-033 rst pulsed mid-MC_WAIT without clk edge -> outputs 0, state=0, stall_cycles=0 immediately.
